// File: rtl/stream_mux_rr_pkg.sv
// Shared types for the round-robin stream multiplexer.
// Pulls in the mode defines and the clog2 helper so importers see one namespace.
package stream_mux_rr_pkg;
`include "stream_mux_rr_defs.sv"

   // Output stage occupancy; the encoding doubles as out_valid.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: highest priority goes to the channel just after ptr.
// Produces a one-hot grant, or all zeros when nothing is requesting.
module rr_arbiter #(
   parameter int NCH  = 4,
   parameter int SELW = 2
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  gnt
);

   logic [NCH-1:0] upper_mask;
   logic [NCH-1:0] upper_req;
   logic [NCH-1:0] pick;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
         assign upper_mask[gi] = (SELW'(gi) > ptr);
      end
   endgenerate

   // Requests above ptr win; if none, the wrap-around set (0..ptr) is used instead.
   assign upper_req = req & upper_mask;
   assign pick      = (|upper_req) ? upper_req : req;
   assign gnt       = pick & (~pick + NCH'(1));

endmodule

// File: rtl/stream_mux_rr_defs.sv
// Verilog-2001 include header: mode encodings and a constant-foldable clog2.
// Guarded so it may be both compiled directly and included by the package.
`ifndef STREAM_MUX_RR_DEFS_SV
`define STREAM_MUX_RR_DEFS_SV

`define MODE_FIXED 1'b0
`define MODE_RR    1'b1

function integer sm_clog2;
   input integer value;
   integer v;
   begin
      v = value - 1;
      sm_clog2 = 0;
      while (v > 0) begin
         sm_clog2 = sm_clog2 + 1;
         v = v >> 1;
      end
   end
endfunction

`endif

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select and round-robin modes.
// Single registered output stage; a drain and a load may happen in the same cycle.
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter  int NCH  = 4,
   parameter  int W    = 8,
   localparam int SELW = sm_clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*W-1:0]  in_data,
   input  logic [NCH-1:0]    in_valid,
   output logic [NCH-1:0]    in_ready,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_ch,
   output logic              out_valid,
   input  logic              out_ready
);

   out_state_t      state_reg, state_next;
   logic [W-1:0]    data_reg, data_next;
   logic [SELW-1:0] ch_reg, ch_next;
   logic [SELW-1:0] rr_ptr_reg, rr_ptr_next;

   logic            load;
   logic            transfer;
   logic [NCH-1:0]  fix_gnt;
   logic [NCH-1:0]  rr_gnt;
   logic [NCH-1:0]  gnt;
   logic [W-1:0]    data_chain [NCH+1];
   logic [SELW-1:0] ch_chain   [NCH+1];

   rr_arbiter #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_arb (
      .req (in_valid),
      .ptr (rr_ptr_reg),
      .gnt (rr_gnt)
   );

   assign data_chain[0] = '0;
   assign ch_chain[0]   = '0;

   // sel values >= NCH match no channel, so they simply yield no grant.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         assign fix_gnt[gi]      = (sel == SELW'(gi)) && in_valid[gi];
         assign data_chain[gi+1] = data_chain[gi] | (in_data[gi*W +: W] & {W{gnt[gi]}});
         assign ch_chain[gi+1]   = ch_chain[gi] | (gnt[gi] ? SELW'(gi) : '0);
      end
   endgenerate

   assign gnt      = (mode == `MODE_RR) ? rr_gnt : fix_gnt;
   assign load     = !rst && ((state_reg == OUT_EMPTY) || out_ready);
   assign in_ready = load ? gnt : '0;
   assign transfer = load && (|gnt);

   always_comb begin
      state_next  = state_reg;
      data_next   = data_reg;
      ch_next     = ch_reg;
      rr_ptr_next = rr_ptr_reg;
      if (transfer) begin
         state_next = OUT_FULL;
         data_next  = data_chain[NCH];
         ch_next    = ch_chain[NCH];
         if (mode == `MODE_RR) begin
            rr_ptr_next = ch_chain[NCH];
         end
      end else if ((state_reg == OUT_FULL) && out_ready) begin
         state_next = OUT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= OUT_EMPTY;
         data_reg   <= '0;
         ch_reg     <= '0;
         rr_ptr_reg <= SELW'(NCH - 1);
      end else begin
         state_reg  <= state_next;
         data_reg   <= data_next;
         ch_reg     <= ch_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   assign out_valid = (state_reg == OUT_FULL);
   assign out_data  = data_reg;
   assign out_ch    = ch_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr (NCH=4, W=8): directed scenarios plus random traffic,
// all checked each cycle against a queue-free behavioural model of the mux.
module tb_stream_mux_rr;

   localparam int NCH = 4;
   localparam int W   = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH*W-1:0] in_data;
   logic [NCH-1:0]   in_valid;
   logic [NCH-1:0]   in_ready;
   logic             mode;
   logic [1:0]       sel;
   logic [W-1:0]     out_data;
   logic [1:0]       out_ch;
   logic             out_valid;
   logic             out_ready;

   int checks = 0;
   int errors = 0;

   // Model state: the word the consumer should currently see and the last RR winner.
   bit         m_valid = 1'b0;
   logic [7:0] m_data  = '0;
   int         m_ch    = 0;
   int         m_ptr   = NCH - 1;
   int         mg;

   stream_mux_rr #(.NCH(NCH), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant();
      if (mode == 1'b0) begin
         if (int'(sel) < NCH && in_valid[sel]) return int'(sel);
         return -1;
      end
      for (int k = 1; k <= NCH; k++) begin
         int c = (m_ptr + k) % NCH;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [NCH-1:0] model_ready();
      logic [NCH-1:0] r = '0;
      int g;
      if (!rst && (!m_valid || out_ready)) begin
         g = model_grant();
         if (g >= 0) r[g] = 1'b1;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_ch    = 0;
         m_ptr   = NCH - 1;
      end else begin
         mg = model_grant();
         if ((!m_valid || out_ready) && mg >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[mg*W +: W];
            m_ch    = mg;
            if (mode) m_ptr = mg;
            $display("xfer t=%0t ch=%0d data=%02h mode=%0d", $time, mg, m_data, mode);
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check("in_ready", 32'(in_ready), 32'(model_ready()));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check("out_data", 32'(out_data), 32'(m_data));
         check("out_ch", 32'(out_ch), m_ch);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rr_data();
      for (int i = 0; i < NCH; i++) in_data[i*W +: W] = 8'(8'h10 + i);
   endtask

   int rr_seq[6]   = '{0, 1, 2, 3, 0, 1};
   int skip_seq[4] = '{3, 1, 3, 1};

   initial begin
      rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = '1; out_ready = 1'b1;
      in_data = 32'h33221100;

      // Reset holds everything quiet even with every channel valid.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid), 32'h0);
         check("rst_out_data", 32'(out_data), 32'h0);
         check("rst_in_ready", 32'(in_ready), 32'h0);
      end
      tick();

      // Fixed select of channel 2.
      rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
      in_data[2*W +: W] = 8'hA5;
      @(negedge clk);
      check("fix_in_ready", 32'(in_ready), 32'h4);
      tick();
      @(negedge clk);
      check("fix_out_data", 32'(out_data), 32'hA5);
      check("fix_out_ch", 32'(out_ch), 32'h2);
      check("fix_out_valid", 32'(out_valid), 32'h1);
      tick();

      // Round-robin fairness; fixed-mode transfers left the pointer at NCH-1.
      mode = 1'b1; set_rr_data();
      for (int k = 0; k < 6; k++) begin
         tick();
         @(negedge clk);
         check("rr_out_ch", 32'(out_ch), rr_seq[k]);
         check("rr_out_data", 32'(out_data), 32'(8'h10 + rr_seq[k]));
      end

      // Skip idle channels: only 1 and 3 request.
      tick();
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         check("skip_out_ch", 32'(out_ch), skip_seq[k]);
      end

      // Backpressure on a held word from channel 3.
      tick();
      out_ready = 1'b0; in_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'h0);
         check("bp_out_ch", 32'(out_ch), 32'h3);
         check("bp_out_data", 32'(out_data), 32'h13);
         check("bp_out_valid", 32'(out_valid), 32'h1);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 32'(in_ready), 32'h1);
      tick();
      @(negedge clk);
      check("bp_reload_ch", 32'(out_ch), 32'h0);
      check("bp_reload_data", 32'(out_data), 32'h10);
      check("bp_reload_valid", 32'(out_valid), 32'h1);

      // Mid-stream reset with a held word and the pointer at 2.
      tick();
      tick();
      out_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("mrst_in_ready", 32'(in_ready), 32'h0);
      check("mrst_held_ch", 32'(out_ch), 32'h2);
      tick();
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("mrst_out_valid", 32'(out_valid), 32'h0);
      check("mrst_first_ready", 32'(in_ready), 32'h1);
      tick();
      @(negedge clk);
      check("mrst_first_ch", 32'(out_ch), 32'h0);

      // Random traffic, checked every cycle by the compare process.
      for (int n = 0; n < 800; n++) begin
         tick();
         rst       = ($urandom_range(0, 63) == 0);
         mode      = 1'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 9) < 7);
      end
      tick();
      rst = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
